// File: rtl/fifo_rd_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_reader
// Description : Read-side consumer for a FIFO with one-cycle registered read
//               latency. Pops words from the FIFO and re-presents them as a
//               valid/ready stream through a 2-entry skid buffer, sustaining
//               one word per cycle under back-pressure. Marks packet
//               boundaries with out_last every PKT_LEN words and counts the
//               delivered words.
// Ports       : clk, rstn           - clock, asynchronous active-low reset
//               en                  - allow new FIFO pops
//               clear               - synchronous flush (highest priority)
//               fifo_empty          - FIFO empty flag
//               fifo_rd_en          - FIFO pop request
//               fifo_rd_data        - FIFO data, valid the cycle after a pop
//               out_valid/ready     - stream handshake
//               out_data, out_last  - stream payload and end-of-packet flag
//               word_cnt            - delivered-word counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clear,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(PKT_LEN - 1);

    // Skid buffer: r_head_q is always the oldest entry, r_tail_q the second.
    logic [1:0]       r_occ_q,      w_occ_d;
    logic             r_inflight_q, w_inflight_d;
    logic [WIDTH-1:0] r_head_q,     w_head_d;
    logic [WIDTH-1:0] r_tail_q,     w_tail_d;
    logic [CNT_W-1:0] r_pkt_idx_q,  w_pkt_idx_d;
    logic [CNT_W-1:0] r_word_cnt_q, w_word_cnt_d;

    logic       w_pop;
    logic       w_push;
    logic       w_rd_en;
    logic [2:0] w_level;

    assign w_pop  = (r_occ_q != 2'd0) && out_ready;
    assign w_push = r_inflight_q;

    // Words that will be held (buffered + arriving) after this edge. Issuing
    // a pop only while this is below 2 guarantees the buffer never overflows
    // when the popped word lands next cycle. A pop can only happen with a
    // non-empty buffer, so the subtraction never underflows.
    assign w_level = {1'b0, r_occ_q} + {2'b00, r_inflight_q} - {2'b00, w_pop};

    // rstn gates the request so the FIFO sees no pop while in reset.
    assign w_rd_en = rstn && en && !clear && !fifo_empty && (w_level < 3'd2);

    always_comb begin
        w_occ_d      = r_occ_q;
        w_inflight_d = w_rd_en;
        w_head_d     = r_head_q;
        w_tail_d     = r_tail_q;
        w_pkt_idx_d  = r_pkt_idx_q;
        w_word_cnt_d = r_word_cnt_q;

        if (clear) begin
            // Buffered words and the word arriving this cycle are discarded.
            w_occ_d      = 2'd0;
            w_inflight_d = 1'b0;
            w_pkt_idx_d  = '0;
            w_word_cnt_d = '0;
        end else begin
            if (w_pop) begin
                w_word_cnt_d = r_word_cnt_q + CNT_W'(1);
                if (r_pkt_idx_q == c_LAST_IDX) begin
                    w_pkt_idx_d = '0;
                end else begin
                    w_pkt_idx_d = r_pkt_idx_q + CNT_W'(1);
                end
            end

            case ({w_push, w_pop})
                2'b10: begin
                    // Write only: append at the tail.
                    if (r_occ_q == 2'd0) begin
                        w_head_d = fifo_rd_data;
                        w_occ_d  = 2'd1;
                    end else begin
                        w_tail_d = fifo_rd_data;
                        w_occ_d  = 2'd2;
                    end
                end
                2'b01: begin
                    // Pop only: shift the second entry up to the head.
                    w_head_d = r_tail_q;
                    w_occ_d  = r_occ_q - 2'd1;
                end
                2'b11: begin
                    // Pop and write together: occupancy is unchanged.
                    if (r_occ_q == 2'd1) begin
                        w_head_d = fifo_rd_data;
                    end else begin
                        w_head_d = r_tail_q;
                        w_tail_d = fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ_q      <= 2'd0;
            r_inflight_q <= 1'b0;
            r_head_q     <= '0;
            r_tail_q     <= '0;
            r_pkt_idx_q  <= '0;
            r_word_cnt_q <= '0;
        end else begin
            r_occ_q      <= w_occ_d;
            r_inflight_q <= w_inflight_d;
            r_head_q     <= w_head_d;
            r_tail_q     <= w_tail_d;
            r_pkt_idx_q  <= w_pkt_idx_d;
            r_word_cnt_q <= w_word_cnt_d;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = (r_occ_q != 2'd0);
    assign out_data   = r_head_q;
    assign out_last   = (r_occ_q != 2'd0) && (r_pkt_idx_q == c_LAST_IDX);
    assign word_cnt   = r_word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream_reader
// Description : Self-checking bench for fifo_rd_stream_reader. A behavioural
//               FIFO feeds the block; a queue-based reference model tracks the
//               words popped from the FIFO and predicts stream contents,
//               packet marks, counter value and pop requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream_reader;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic             clear;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [CNT_W-1:0] word_cnt;

    always #5 clk = ~clk;

    fifo_rd_stream_reader #(
        .WIDTH  (WIDTH),
        .PKT_LEN(PKT_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .clear       (clear),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .word_cnt    (word_cnt)
    );

    // ------------------------------------------------------------------
    // Behavioural FIFO: registered read data, ignores rd_en when empty.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fmem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fmem[rd_ptr % 1024];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic fifo_write(input logic [WIDTH-1:0] d);
        fmem[wr_ptr % 1024] = d;
        wr_ptr++;
    endtask

    // ------------------------------------------------------------------
    // Reference model: words taken from the FIFO but not yet delivered.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] exp_q [$];
    int delivered = 0;
    bit last_pop  = 1'b0;
    bit s_hs      = 1'b0;
    int n_vec     = 0;
    int n_fail    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs at the falling edge and advance the model by the
    // events the next rising edge will commit.
    task automatic sample();
        int outst;
        bit exp_valid;
        bit exp_rd;
        bit pp;
        logic [CNT_W-1:0] ecnt;
        @(negedge clk);
        if (!rstn) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_fifo_rd_en", fifo_rd_en, 0);
            check("rst_word_cnt", word_cnt, 0);
            exp_q.delete();
            delivered = 0;
            last_pop  = 1'b0;
            s_hs      = 1'b0;
            return;
        end
        outst     = exp_q.size();
        exp_valid = (outst - int'(last_pop)) > 0;
        s_hs      = exp_valid && out_ready;
        exp_rd    = en && !clear && !fifo_empty && ((outst - int'(s_hs)) < 2);
        ecnt      = CNT_W'(delivered);

        check("out_valid", out_valid, exp_valid);
        check("fifo_rd_en", fifo_rd_en, exp_rd);
        check("occupancy_le_2", outst, (outst > 2) ? 2 : outst);
        check("word_cnt", word_cnt, ecnt);
        if (exp_valid) begin
            check("out_data", out_data, exp_q[0]);
            check("out_last", out_last, (delivered % PKT_LEN) == PKT_LEN - 1);
        end else begin
            check("out_last_idle", out_last, 0);
        end

        pp = fifo_rd_en && !fifo_empty;
        if (clear) begin
            exp_q.delete();
            delivered = 0;
            last_pop  = 1'b0;
        end else begin
            if (s_hs) begin
                void'(exp_q.pop_front());
                delivered++;
            end
            if (pp) exp_q.push_back(fmem[rd_ptr % 1024]);
            last_pop = pp;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        sample();
        advance();
        clear = 1'b0;
    endtask

    typedef struct {
        bit               en;
        bit               rdy;
        bit               e_rd;
        bit               e_valid;
        logic [WIDTH-1:0] e_data;
        bit               e_last;
        int               e_cnt;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int hs_n, rd_n, first_c, last_c, rd_first, rd_last, w, nxt, ar_head;
        logic [15:0] mask;
        logic [WIDTH-1:0] got [$];
        bit any_rd, any_valid;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd23, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd56, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 2};

        rstn = 1'b1; en = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        repeat (2) begin sample(); advance(); end
        rstn = 1'b1;

        // ---------------- sanity (table driven) ----------------
        fifo_write(8'd23);
        fifo_write(8'd56);
        foreach (tbl[i]) begin
            en = tbl[i].en;
            out_ready = tbl[i].rdy;
            sample();
            check("tbl_rd_en", fifo_rd_en, tbl[i].e_rd);
            check("tbl_valid", out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check("tbl_data", out_data, tbl[i].e_data);
                check("tbl_last", out_last, tbl[i].e_last);
            end
            check("tbl_cnt", word_cnt, tbl[i].e_cnt);
            advance();
        end

        // ---------------- full-rate drain ----------------
        do_clear();
        for (int i = 0; i < 16; i++) fifo_write(WIDTH'(i));
        hs_n = 0; rd_n = 0; first_c = -1; last_c = -1; rd_first = -1; rd_last = -1; mask = '0;
        for (int c = 0; c < 24; c++) begin
            sample();
            if (fifo_rd_en) begin
                rd_n++;
                if (rd_first < 0) rd_first = c;
                rd_last = c;
            end
            if (s_hs) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                if (out_last) mask[hs_n % 16] = 1'b1;
                hs_n++;
            end
            advance();
        end
        check("fr_rd_cycles", rd_n, 16);
        check("fr_rd_span", rd_last - rd_first, 15);
        check("fr_handshakes", hs_n, 16);
        check("fr_no_bubble", last_c - first_c, 15);
        check("fr_last_mask", mask, 16'h8888);
        check("fr_word_cnt", word_cnt, 16);
        check("fr_valid_after", out_valid, 0);

        // ---------------- back-pressure ----------------
        do_clear();
        for (int i = 0; i < 8; i++) fifo_write(WIDTH'(8'h30 + i));
        en = 1'b1; out_ready = 1'b0;
        w = 0;
        sample();
        while (!out_valid && w < 10) begin advance(); sample(); w++; end
        check("bp_valid_seen", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) sample();
            check("bp_hold_data", out_data, 8'h30);
            check("bp_rd_en_low", fifo_rd_en, 0);
            advance();
        end
        check("bp_occ_full", exp_q.size() - int'(last_pop), 2);
        out_ready = 1'b1;
        got.delete();
        repeat (14) begin
            sample();
            if (s_hs) got.push_back(out_data);
            advance();
        end
        check("bp_count", got.size(), 8);
        foreach (got[i]) check("bp_order", got[i], 8'h30 + i);
        check("bp_word_cnt", word_cnt, 8);

        // ---------------- empty / underflow ----------------
        do_clear();
        any_rd = 1'b0; any_valid = 1'b0;
        repeat (20) begin
            sample();
            any_rd    |= fifo_rd_en;
            any_valid |= out_valid;
            advance();
        end
        check("empty_rd_en", any_rd, 0);
        check("empty_valid", any_valid, 0);
        check("empty_cnt", word_cnt, 0);
        fifo_write(8'hA5);
        got.delete();
        repeat (8) begin
            sample();
            if (s_hs) got.push_back(out_data);
            advance();
        end
        check("single_count", got.size(), 1);
        if (got.size() > 0) check("single_data", got[0], 8'hA5);
        check("single_cnt", word_cnt, 1);

        // ---------------- clear mid-stream ----------------
        do_clear();
        for (int i = 0; i < 12; i++) fifo_write(WIDTH'(8'h50 + i));
        hs_n = 0; w = 0;
        while (hs_n < 5 && w < 20) begin
            sample();
            if (s_hs) hs_n++;
            advance();
            w++;
        end
        check("clr_5_handshakes", hs_n, 5);
        check("clr_pop_inflight", last_pop, 1);
        nxt = int'(fmem[rd_ptr % 1024]);
        clear = 1'b1;
        sample();
        advance();
        clear = 1'b0;
        sample();
        check("clr_word_cnt", word_cnt, 0);
        check("clr_valid", out_valid, 0);
        advance();
        got.delete(); mask = '0;
        repeat (12) begin
            sample();
            if (s_hs) begin
                if (out_last) mask[got.size() % 16] = 1'b1;
                got.push_back(out_data);
            end
            advance();
        end
        check("clr_after_count", got.size(), 5);
        if (got.size() > 0) check("clr_next_word", got[0], nxt);
        check("clr_last_restart", mask, 16'h0008);

        // ---------------- async reset mid-operation ----------------
        do_clear();
        for (int i = 0; i < 8; i++) fifo_write(WIDTH'(8'h70 + i));
        out_ready = 1'b0;
        repeat (4) begin sample(); advance(); end
        out_ready = 1'b1;
        sample(); advance();
        out_ready = 1'b0;
        sample(); advance();
        check("ar_occ_full", exp_q.size() - int'(last_pop), 2);
        check("ar_cnt_before", word_cnt, 1);
        ar_head = int'(fmem[rd_ptr % 1024]);
        #2 rstn = 1'b0;
        #1;
        check("ar_valid_now", out_valid, 0);
        check("ar_rd_en_now", fifo_rd_en, 0);
        check("ar_cnt_now", word_cnt, 0);
        sample(); advance();
        rstn = 1'b1;
        out_ready = 1'b1;
        got.delete();
        repeat (12) begin
            sample();
            if (s_hs) got.push_back(out_data);
            advance();
        end
        check("ar_resume_count", got.size(), 5);
        if (got.size() > 0) check("ar_resume_head", got[0], ar_head);

        // ---------------- randomized run against the model ----------------
        do_clear();
        for (int c = 0; c < 1500; c++) begin
            en        = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 99) == 0);
            if (($urandom_range(0, 1) == 1) && (wr_ptr - rd_ptr) < 32)
                fifo_write(WIDTH'($urandom_range(0, 255)));
            sample();
            advance();
        end
        clear = 1'b0; en = 1'b1; out_ready = 1'b1;
        w = 0;
        while ((wr_ptr != rd_ptr || exp_q.size() != 0) && w < 200) begin
            sample();
            advance();
            w++;
        end
        check("rand_drained", (wr_ptr != rd_ptr) || (exp_q.size() != 0), 0);
        sample();
        check("rand_final_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
